// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction fetch controller:
//          address/data widths, prefetch buffer depth, controller state
//          encoding and the {pc, instr} buffer entry.
// Rev    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [0:0] {
    ST_VEC = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Two-entry prefetch buffer of {pc, instr} records. Supports a push
//          and a pop in the same cycle (also when full) and a synchronous
//          flush that empties the buffer and drops any same-cycle push.
// Ports  : clk, rst_n       clock / async active-low reset
//          flush_i          empty the buffer (wins over push/pop)
//          push_i, entry_i  enqueue request and record
//          pop_i            consumer ready; a pop happens when valid_o && pop_i
//          head_o, valid_o  head record and its valid flag
//          push_ok_o        a push this cycle would be accepted
// Rev    : 1.0  initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic         push_ok_o
);

  // Head/tail shift structure: the head register feeds the outputs directly,
  // so the presented record is stable until it is popped.
  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  logic w_pop;
  logic w_push;
  logic w_full;

  assign w_full    = (count_q == 2'(FIFO_DEPTH));
  assign w_pop     = pop_i && (count_q != 2'd0);
  assign push_ok_o = !w_full || w_pop;
  assign w_push    = push_i && push_ok_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = entry_i;
          end else begin
            head_d = tail_q;
            tail_d = entry_i;
          end
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = entry_i;
          end else begin
            tail_d = entry_i;
          end
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (count_q != 2'd0);

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fetch_ctrl
// Brief  : Instruction fetch controller. After reset it spends one cycle
//          loading the reset vector, then streams sequential ROM bytes into a
//          two-entry prefetch buffer. Branches (and, optionally, interrupt
//          entry / return) flush the buffer and redirect the fetch pointer.
// Config : FETCH_IRQ_EN - when defined, builds interrupt entry/return logic
//          (irq, rti, vec_irq, irq_ack). Otherwise those inputs are ignored
//          and irq_ack is tied low.
// Ports  : clk, rst_n             clock / async active-low reset
//          imem_addr, imem_data   combinational instruction ROM port
//          vec_reset, vec_irq     reset and interrupt vectors
//          out_instr/out_pc/out_valid/out_ready  instruction stream handshake
//          br_taken, br_target    branch redirect pulse and target
//          irq, rti, irq_ack      interrupt request, return, entry pulse
// Rev    : 1.0  initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic [ADDR_W-1:0] vec_reset,
  input  logic [ADDR_W-1:0] vec_irq,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              irq,
  input  logic              rti,
  output logic              irq_ack
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

  logic              w_run;
  logic              w_flush;
  logic              w_push;
  logic              w_push_ok;
  logic              w_irq_take;
  logic              w_rti_take;
  logic [ADDR_W-1:0] w_saved_pc;
  fetch_entry_t      w_entry;
  fetch_entry_t      w_head;

  assign w_run = (state_q == ST_RUN);

`ifdef FETCH_IRQ_EN
  logic [ADDR_W-1:0] saved_pc_q, saved_pc_d;
  logic              in_handler_q, in_handler_d;
  logic              irq_ack_q;

  // A branch in the same cycle wins; rti is a pulse and is simply lost,
  // while a held irq level is taken on a later cycle.
  assign w_rti_take = w_run && rti && in_handler_q && !br_taken;
  assign w_irq_take = w_run && irq && !in_handler_q && !br_taken;
  assign w_saved_pc = saved_pc_q;

  always_comb begin
    saved_pc_d   = saved_pc_q;
    in_handler_d = in_handler_q;
    if (w_irq_take) begin
      // Resume at the oldest instruction not yet consumed.
      saved_pc_d   = out_valid ? w_head.pc : fetch_pc_q;
      in_handler_d = 1'b1;
    end else if (w_rti_take) begin
      in_handler_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saved_pc_q   <= '0;
      in_handler_q <= 1'b0;
      irq_ack_q    <= 1'b0;
    end else begin
      saved_pc_q   <= saved_pc_d;
      in_handler_q <= in_handler_d;
      irq_ack_q    <= w_irq_take;
    end
  end

  assign irq_ack = irq_ack_q;
`else
  logic w_unused_irq;

  assign w_rti_take   = 1'b0;
  assign w_irq_take   = 1'b0;
  assign w_saved_pc   = '0;
  assign irq_ack      = 1'b0;
  assign w_unused_irq = ^{irq, rti, vec_irq};
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    w_flush    = 1'b0;
    w_push     = 1'b0;
    case (state_q)
      ST_VEC: begin
        fetch_pc_d = vec_reset;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (br_taken) begin
          w_flush    = 1'b1;
          fetch_pc_d = br_target;
        end else if (w_rti_take) begin
          w_flush    = 1'b1;
          fetch_pc_d = w_saved_pc;
        end else if (w_irq_take) begin
          w_flush    = 1'b1;
          fetch_pc_d = vec_irq;
        end else if (w_push_ok) begin
          w_push     = 1'b1;
          fetch_pc_d = fetch_pc_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_VEC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_VEC;
      fetch_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign imem_addr     = fetch_pc_q;
  assign w_entry.pc    = fetch_pc_q;
  assign w_entry.instr = imem_data;

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (w_flush),
    .push_i    (w_push),
    .entry_i   (w_entry),
    .pop_i     (out_ready),
    .head_o    (w_head),
    .valid_o   (out_valid),
    .push_ok_o (w_push_ok)
  );

  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

endmodule
`default_nettype wire
